match_controller: RTL and testbench
===================================

# match_controller

Sequencing FSM for a Pong match. It sits between the bounce/score detector and the ball mover. It consumes the detector's 2-bit `bounce` event code and owns the authoritative score registers. It gates ball motion, requests ball re-centering, and chooses serve direction through the IDLE → SERVE → PLAY → POINT → OVER sequence, paced by a per-frame tick.

## Interface
- `SCREEN_X`, 640: screen width in pixels; the midline `SCREEN_X/2` decides which player scored.
- `WIN_SCORE`, 9: score that ends the match, legal range 1..15.
- `SERVE_FRAMES`, 60: frame ticks spent frozen before each serve, must be ≥1.
- `POINT_FRAMES`, 30: frame ticks spent frozen after a point, must be ≥1.
- `clock` in 1: system clock. One clock; reset is synchronous and active-low.
- `reset_n` in 1: synchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse, once per video frame.
- `start` in 1: start button, level; only its rising edge is used.
- `pause` in 1: level; while high, play and countdowns freeze.
- `bounce` in 2: event code. 00 none, 01 paddle, 10 wall, 11 point scored.
- `ball_pos_x` in 10: ball x position, sampled when `bounce`=11.
- `ball_enable` out 1: ball mover may advance the ball.
- `ball_reset` out 1: one-cycle pulse that re-centers the ball.
- `serve_dir` out 1: 0 = serve toward player 1 (left), 1 = serve toward player 2 (right).
- `score_player_1` out 4: player 1 score.
- `score_player_2` out 4: player 2 score.
- `game_over` out 1: high while in OVER.
- `winner` out 1: 0 = player 1, 1 = player 2; valid while `game_over`=1.

## Operation
- **Reset values** (when `reset_n`=0 at an edge):
  - state IDLE, both scores 0, frame counter 0, `start_q` 0.
  - `ball_enable`, `ball_reset`, `serve_dir`, `game_over`, `winner` all 0.
- **Start edge:** `start_edge` = `start` & ~`start_q`. `start_q` is registered every cycle. If `start` is held high through reset, an edge is seen on the first cycle after reset.
- **IDLE:** ball frozen. On `start_edge`:
  - clear both scores, pulse `ball_reset`, `serve_dir` ← 0;
  - load counter ← `SERVE_FRAMES`, go to SERVE.
- **SERVE:** `ball_enable`=0.
  - Each `frame_tick` with `pause`=0 decrements the counter.
  - A tick that finds counter = 1 moves to PLAY, so SERVE lasts exactly `SERVE_FRAMES` unpaused ticks.
- **PLAY:** `ball_enable` = ~`pause`.
  - `bounce` 01/10 are ignored; the ball FSM handles them.
  - `bounce`=11 with `pause`=0 awards a point:
    - `ball_pos_x` ≥ `SCREEN_X/2` → player 1 scores, `serve_dir` ← 1.
    - Otherwise player 2 scores, `serve_dir` ← 0.
    - The ball is always served toward the player who conceded.
  - Score increments saturate at 15.
  - If the new score equals `WIN_SCORE`: go to OVER, set `game_over`=1 and `winner` to the scorer.
  - Otherwise: counter ← `POINT_FRAMES`, go to POINT.
- **POINT:** `ball_enable`=0; all `bounce` codes ignored, so a level held at 11 scores only once.
  - Unpaused `frame_tick`s decrement the counter.
  - The tick at counter = 1 pulses `ball_reset`, loads counter ← `SERVE_FRAMES`, and goes to SERVE.
- **OVER:** scores and `winner` held, `ball_enable`=0. On `start_edge`: clear `game_over`, then same actions as the IDLE start.
- `start_edge` is ignored in SERVE, PLAY and POINT.
- `frame_tick` has no effect in PLAY, IDLE or OVER.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `bounce`=11 sampled at edge N → updated score, state change and `ball_enable`=0 are visible after edge N. The detector's output latency of one cycle adds on top of this.
- `ball_reset` is high for exactly one cycle, beginning with the edge that enters SERVE.
- SERVE → PLAY: `ball_enable` rises on the edge that samples the final `frame_tick`.
- Simultaneous `frame_tick` and `bounce`=11 in PLAY: the point is taken. Simultaneous `pause` and anything: `pause` wins; no decrement, no score.
- Reset mid-operation: all reset values apply after the next edge with `reset_n`=0, regardless of state. A `ball_reset` pulse in progress is dropped.

## Test plan
Bench parameters: `SERVE_FRAMES`=3, `POINT_FRAMES`=2, `WIN_SCORE`=3.

1. Reset, then pulse `start` → `ball_reset`=1 for 1 cycle. `ball_enable` stays 0 for exactly 3 `frame_tick`s, then rises on the 3rd tick edge.
2. In PLAY, hold `bounce`=11 for 5 cycles with `ball_pos_x`=630 → `score_player_1`=1 (only once), `serve_dir`=1. After 2 ticks, a `ball_reset` pulse and re-entry into SERVE.
3. In PLAY, `bounce`=11 with `ball_pos_x`=3 → `score_player_2`+1, `serve_dir`=0. Also `bounce`=01 and `bounce`=10 in PLAY → no state or score change.
4. Drive player 2 to 3 points → `game_over`=1, `winner`=1, scores frozen. Later `bounce`/`frame_tick` activity → no change. Then `start` edge → scores 0/0, `game_over`=0, SERVE.
5. `pause`=1 during SERVE with 5 `frame_tick`s → counter frozen. In PLAY, `pause`=1 with `bounce`=11 → `ball_enable`=0, no score.
6. Assert `reset_n`=0 for 1 cycle mid-POINT with scores 2/1 → next cycle IDLE, scores 0/0, all outputs 0.

Source files
------------

// File: rtl/match_controller.sv
// Pong match sequencer: owns the score registers and walks IDLE -> SERVE -> PLAY -> POINT -> OVER,
// gating ball motion and requesting re-centres, paced by the per-frame tick.
module match_controller #(
  parameter int unsigned SCREEN_X     = 640,
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] bounce,
  input  logic [9:0] ball_pos_x,
  output logic       ball_enable,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_player_1,
  output logic [3:0] score_player_2,
  output logic       game_over,
  output logic       winner
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StServe = 3'd1;
  localparam logic [2:0] StPlay  = 3'd2;
  localparam logic [2:0] StPoint = 3'd3;
  localparam logic [2:0] StOver  = 3'd4;

  localparam int unsigned   CntW      = 16;
  localparam logic [CntW-1:0] ServeLoad = CntW'(SERVE_FRAMES);
  localparam logic [CntW-1:0] PointLoad = CntW'(POINT_FRAMES);
  localparam logic [9:0]    MidX      = 10'(SCREEN_X / 2);
  localparam logic [3:0]    WinScore  = 4'(WIN_SCORE);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            start_q;
  logic [3:0]      s1_q, s1_d, s2_q, s2_d;
  logic            en_q, en_d, rst_q, rst_d, dir_q, dir_d, over_q, over_d, win_q, win_d;

  logic       start_edge, run_tick;
  logic [3:0] s1_inc, s2_inc;

  assign start_edge = start & ~start_q;
  assign run_tick   = frame_tick & ~pause;
  assign s1_inc     = (s1_q == 4'd15) ? 4'd15 : s1_q + 4'd1;
  assign s2_inc     = (s2_q == 4'd15) ? 4'd15 : s2_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    rst_d   = 1'b0;
    dir_d   = dir_q;
    over_d  = over_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle, StOver: begin
        if (start_edge) begin
          s1_d    = 4'd0;
          s2_d    = 4'd0;
          rst_d   = 1'b1;
          dir_d   = 1'b0;
          over_d  = 1'b0;
          cnt_d   = ServeLoad;
          state_d = StServe;
        end
      end
      StServe: begin
        if (run_tick) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_d = StPlay;
        end
      end
      StPlay: begin
        if (bounce == 2'b11 && !pause) begin
          // Serve always goes toward the player who conceded.
          if (ball_pos_x >= MidX) begin
            s1_d  = s1_inc;
            dir_d = 1'b1;
          end else begin
            s2_d  = s2_inc;
            dir_d = 1'b0;
          end
          if ((ball_pos_x >= MidX) ? (s1_inc == WinScore) : (s2_inc == WinScore)) begin
            over_d  = 1'b1;
            win_d   = (ball_pos_x < MidX);
            state_d = StOver;
          end else begin
            cnt_d   = PointLoad;
            state_d = StPoint;
          end
        end
      end
      StPoint: begin
        if (run_tick) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            rst_d   = 1'b1;
            cnt_d   = ServeLoad;
            state_d = StServe;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    en_d = (state_d == StPlay) && !pause;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      start_q <= 1'b0;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      en_q    <= 1'b0;
      rst_q   <= 1'b0;
      dir_q   <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      en_q    <= en_d;
      rst_q   <= rst_d;
      dir_q   <= dir_d;
      over_q  <= over_d;
      win_q   <= win_d;
    end
  end

  assign ball_enable    = en_q;
  assign ball_reset     = rst_q;
  assign serve_dir      = dir_q;
  assign score_player_1 = s1_q;
  assign score_player_2 = s2_q;
  assign game_over      = over_q;
  assign winner         = win_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a phase/tick-count model.
module tb_match_controller;

  localparam int unsigned SX = 640;
  localparam int unsigned WS = 3;
  localparam int unsigned SF = 3;
  localparam int unsigned PF = 2;

  localparam int PhIdle = 0, PhServe = 1, PhPlay = 2, PhPoint = 3, PhOver = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0, frame_tick = 1'b0, start = 1'b0, pause = 1'b0;
  logic [1:0] bounce = 2'b00;
  logic [9:0] ball_pos_x = 10'd0;
  logic       ball_enable, ball_reset, serve_dir, game_over, winner;
  logic [3:0] score_player_1, score_player_2;

  int errors = 0;
  int checks = 0;

  // Behavioural model: which phase we are in and how many unpaused ticks it has seen.
  int m_phase = PhIdle, m_ticks = 0, m_s1 = 0, m_s2 = 0;
  bit m_prev_start = 0, m_en = 0, m_rst = 0, m_dir = 0, m_go = 0, m_win = 0;

  match_controller #(
    .SCREEN_X(SX), .WIN_SCORE(WS), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)
  ) dut (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .start(start), .pause(pause),
    .bounce(bounce), .ball_pos_x(ball_pos_x), .ball_enable(ball_enable),
    .ball_reset(ball_reset), .serve_dir(serve_dir), .score_player_1(score_player_1),
    .score_player_2(score_player_2), .game_over(game_over), .winner(winner)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic begin_match();
    m_s1 = 0; m_s2 = 0; m_rst = 1; m_dir = 0; m_go = 0;
    m_phase = PhServe; m_ticks = 0;
  endtask

  task automatic model_step(input bit rn, st, ft, ps, input int bc, input int x);
    bit edge_seen, p2;
    int newsc;
    if (!rn) begin
      m_phase = PhIdle; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_prev_start = 0;
      m_en = 0; m_rst = 0; m_dir = 0; m_go = 0; m_win = 0;
      return;
    end
    edge_seen = st && !m_prev_start;
    m_prev_start = st;
    m_rst = 0;
    case (m_phase)
      PhIdle, PhOver: if (edge_seen) begin_match();
      PhServe: if (ft && !ps) begin
        m_ticks++;
        if (m_ticks == SF) m_phase = PhPlay;
      end
      PhPlay: if (bc == 3 && !ps) begin
        p2 = (x < SX / 2);
        if (p2) begin m_s2 = (m_s2 >= 15) ? 15 : m_s2 + 1; newsc = m_s2; end
        else begin m_s1 = (m_s1 >= 15) ? 15 : m_s1 + 1; newsc = m_s1; end
        m_dir = !p2;
        if (newsc == WS) begin m_phase = PhOver; m_go = 1; m_win = p2; end
        else begin m_phase = PhPoint; m_ticks = 0; end
      end
      PhPoint: if (ft && !ps) begin
        m_ticks++;
        if (m_ticks == PF) begin m_rst = 1; m_phase = PhServe; m_ticks = 0; end
      end
      default: ;
    endcase
    m_en = (m_phase == PhPlay) && !ps;
  endtask

  // Drive one cycle, advance the model, then compare every output just after the edge.
  task automatic step(input bit rn, st, ft, ps, input int bc, input int x);
    @(negedge clock);
    reset_n = rn; start = st; frame_tick = ft; pause = ps;
    bounce = 2'(bc); ball_pos_x = 10'(x);
    model_step(rn, st, ft, ps, bc, x);
    @(posedge clock);
    #1;
    chk("ball_enable", 32'(ball_enable), 32'(m_en));
    chk("ball_reset", 32'(ball_reset), 32'(m_rst));
    chk("serve_dir", 32'(serve_dir), 32'(m_dir));
    chk("score_player_1", 32'(score_player_1), 32'(m_s1));
    chk("score_player_2", 32'(score_player_2), 32'(m_s2));
    chk("game_over", 32'(game_over), 32'(m_go));
    chk("winner", 32'(winner), 32'(m_win));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 0, 0, 0);
  endtask

  task automatic point_at(input int x);
    step(1, 0, 0, 0, 3, x);
    step(1, 0, 0, 0, 0, x);
  endtask

  initial begin
    // 1: reset, start, serve countdown
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("reset_enable", 32'(ball_enable), 32'd0);
    chk("reset_scores", 32'({score_player_1, score_player_2}), 32'd0);
    step(1, 1, 0, 0, 0, 0);
    chk("start_ball_reset", 32'(ball_reset), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    chk("ball_reset_one_cycle", 32'(ball_reset), 32'd0);
    ticks(2);
    chk("serve_frozen", 32'(ball_enable), 32'd0);
    ticks(1);
    chk("serve_done_enable", 32'(ball_enable), 32'd1);

    // 2: held point code scores once
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 3, 630);
    chk("held_point_p1", 32'(score_player_1), 32'd1);
    chk("held_point_dir", 32'(serve_dir), 32'd1);
    ticks(1);
    chk("point_wait", 32'(ball_reset), 32'd0);
    ticks(1);
    chk("point_ball_reset", 32'(ball_reset), 32'd1);
    ticks(3);

    // 3: paddle/wall ignored, left-side point
    step(1, 0, 0, 0, 1, 100);
    step(1, 0, 0, 0, 2, 500);
    point_at(3);
    chk("p2_point", 32'(score_player_2), 32'd1);
    chk("p2_dir", 32'(serve_dir), 32'd0);
    ticks(5);
    chk("back_in_play", 32'(ball_enable), 32'd1);

    // 4: player 2 wins, OVER holds, restart
    point_at(319);
    ticks(5);
    point_at(0);
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_winner", 32'(winner), 32'd1);
    chk("over_score", 32'(score_player_2), 32'd3);
    for (int i = 0; i < 6; i++) step(1, 0, i % 2, 0, 3 - (i % 4), 50 * i);
    step(1, 1, 0, 0, 0, 0);
    chk("restart_scores", 32'({score_player_1, score_player_2}), 32'd0);
    chk("restart_over", 32'(game_over), 32'd0);
    chk("restart_ball_reset", 32'(ball_reset), 32'd1);
    step(1, 0, 0, 0, 0, 0);

    // 5: pause freezes countdown and scoring
    for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 0, 0);
    ticks(2);
    chk("pause_froze_serve", 32'(ball_enable), 32'd0);
    ticks(1);
    chk("pause_serve_done", 32'(ball_enable), 32'd1);
    step(1, 0, 0, 1, 3, 3);
    chk("pause_no_enable", 32'(ball_enable), 32'd0);
    chk("pause_no_score", 32'(score_player_2), 32'd0);
    step(1, 0, 0, 0, 0, 0);

    // 6: reset mid-POINT at 2/1
    point_at(630);
    ticks(5);
    point_at(640);
    ticks(5);
    point_at(10);
    chk("pre_reset_scores", 32'({score_player_1, score_player_2}), 32'h21);
    step(0, 0, 1, 0, 0, 0);
    chk("mid_reset_scores", 32'({score_player_1, score_player_2}), 32'd0);
    chk("mid_reset_outputs",
        32'({ball_enable, ball_reset, serve_dir, game_over, winner}), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 639)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
